anubis_inv_gamma_serial: RTL and testbench

Byte-serial inverse nonlinear layer (γ⁻¹) for the ANUBIS decryption datapath. It accepts a 128-bit state word and substitutes each of the 16 bytes through a single shared ANUBIS S-box instance, one byte per clock. It returns the substituted state over a valid/ready handshake. The ANUBIS S-box is an involution, so γ⁻¹ uses the same S mapping as γ; this block is the area-reduced decryption-side counterpart of the combinational substitution layer.

---
 rtl/anubis_inv_gamma_serial_if.sv | 29 ++
 rtl/anubis_inv_gamma_serial.sv | 115 +++++++++++
 tb/tb_anubis_inv_gamma_serial.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/anubis_inv_gamma_serial_if.sv
// Purpose: handshake bundle for the byte-serial ANUBIS inverse nonlinear layer.
// Latency: none (wires only).
// Backpressure: in_valid/in_ready upstream; out_valid/out_ready downstream.
// Ports: in_valid, in_ready, idat, abort (request side);
//        out_valid, out_ready, odat, busy (result side).
interface anubis_inv_gamma_serial_if #(
    parameter int NBYTES = 16
);
    logic                  in_valid;
    logic                  in_ready;
    logic [8*NBYTES-1:0]   idat;
    logic                  abort;
    logic                  out_valid;
    logic                  out_ready;
    logic [8*NBYTES-1:0]   odat;
    logic                  busy;

    // master: the producer/consumer around the block
    modport master (
        output in_valid, idat, abort, out_ready,
        input  in_ready, out_valid, odat, busy
    );

    // slave: the substitution block itself
    modport slave (
        input  in_valid, idat, abort, out_ready,
        output in_ready, out_valid, odat, busy
    );
endinterface

// File: rtl/anubis_inv_gamma_serial.sv
// Purpose: byte-serial ANUBIS gamma^-1 (involutive S-box) over a 128-bit state, one shared S-box.
// Latency: accept at edge E -> out_valid after edge E+16; 18-clock accept-to-accept minimum.
// Backpressure: out_ready low holds DONE with odat stable; in_ready only in IDLE; abort cancels.
// Ports: clk, rst_n (async active-low); bus (slave modport): in_valid/in_ready/idat,
//        abort, out_valid/out_ready/odat, busy.
module anubis_inv_gamma_serial #(
    parameter int NBYTES = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    anubis_inv_gamma_serial_if.slave    bus
);
    localparam int CW = $clog2(NBYTES);
    localparam logic [CW-1:0] LAST = CW'(NBYTES - 1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SUB  = 3'd1,
        DONE = 3'd2
    } state_t;

    // ANUBIS S-box; an involution, so the same table serves gamma and gamma^-1.
    localparam logic [7:0] SBOX [0:255] = '{
        8'hA7, 8'hD3, 8'hE6, 8'h71, 8'hD0, 8'hAC, 8'h4D, 8'h79, 8'h3A, 8'hC9, 8'h91, 8'hFC, 8'h1E, 8'h47, 8'h54, 8'hBD,
        8'h8C, 8'hA5, 8'h7A, 8'hFB, 8'h63, 8'hB8, 8'hDD, 8'hD4, 8'hE5, 8'hB3, 8'hC5, 8'hBE, 8'hA9, 8'h88, 8'h0C, 8'hA2,
        8'h39, 8'hDF, 8'h29, 8'hDA, 8'h2B, 8'hA8, 8'hCB, 8'h4C, 8'h4B, 8'h22, 8'hAA, 8'h24, 8'h41, 8'h70, 8'hA6, 8'hF9,
        8'h5A, 8'hE2, 8'hB0, 8'h36, 8'h7D, 8'hE4, 8'h33, 8'hFF, 8'h60, 8'h20, 8'h08, 8'h8B, 8'h5E, 8'hAB, 8'h7F, 8'h78,
        8'h7C, 8'h2C, 8'h57, 8'hD2, 8'hDC, 8'h6D, 8'h7E, 8'h0D, 8'h53, 8'h94, 8'hC3, 8'h28, 8'h27, 8'h06, 8'h5F, 8'hAD,
        8'h67, 8'h5C, 8'h55, 8'h48, 8'h0E, 8'h52, 8'hEA, 8'h42, 8'h5B, 8'h5D, 8'h30, 8'h58, 8'h51, 8'h59, 8'h3C, 8'h4E,
        8'h38, 8'h8A, 8'h72, 8'h14, 8'hE7, 8'hC6, 8'hDE, 8'h50, 8'h8E, 8'h92, 8'hD1, 8'h77, 8'h93, 8'h45, 8'h9A, 8'hCE,
        8'h2D, 8'h03, 8'h62, 8'hB6, 8'hB9, 8'hBF, 8'h96, 8'h6B, 8'h3F, 8'h07, 8'h12, 8'hAE, 8'h40, 8'h34, 8'h46, 8'h3E,
        8'hDB, 8'hCF, 8'hEC, 8'hCC, 8'hC1, 8'hA1, 8'hC0, 8'hD6, 8'h1D, 8'hF4, 8'h61, 8'h3B, 8'h10, 8'hD8, 8'h68, 8'hA0,
        8'hB1, 8'h0A, 8'h69, 8'h6C, 8'h49, 8'hFA, 8'h76, 8'hC4, 8'h9E, 8'h9B, 8'h6E, 8'h99, 8'hC2, 8'hB7, 8'h98, 8'hBC,
        8'h8F, 8'h85, 8'h1F, 8'hB4, 8'hF8, 8'h11, 8'h2E, 8'h00, 8'h25, 8'h1C, 8'h2A, 8'h3D, 8'h05, 8'h4F, 8'h7B, 8'hB2,
        8'h32, 8'h90, 8'hAF, 8'h19, 8'hA3, 8'hF7, 8'h73, 8'h9D, 8'h15, 8'h74, 8'hEE, 8'hCA, 8'h9F, 8'h0F, 8'h1B, 8'h75,
        8'h86, 8'h84, 8'h9C, 8'h4A, 8'h97, 8'h1A, 8'h65, 8'hF6, 8'hED, 8'h09, 8'hBB, 8'h26, 8'h83, 8'hEB, 8'h6F, 8'h81,
        8'h04, 8'h6A, 8'h43, 8'h01, 8'h17, 8'hE1, 8'h87, 8'hF5, 8'h8D, 8'hE3, 8'h23, 8'h80, 8'h44, 8'h16, 8'h66, 8'h21,
        8'hFE, 8'hD5, 8'h31, 8'hD9, 8'h35, 8'h18, 8'h02, 8'h64, 8'hF2, 8'hF1, 8'h56, 8'hCD, 8'h82, 8'hC8, 8'hBA, 8'hF0,
        8'hEF, 8'hE9, 8'hE8, 8'hFD, 8'h89, 8'hD7, 8'hC7, 8'hB5, 8'hA4, 8'h2F, 8'h95, 8'h13, 8'h0B, 8'hF3, 8'hE0, 8'h37
    };

    state_t              state, state_nxt;
    logic [CW-1:0]       cnt, cnt_nxt;
    logic [8*NBYTES-1:0] data, data_nxt;
    logic [CW+2:0]       boff;
    logic [7:0]          sbox_in, sbox_out;

    // The single S-box sits on the byte lane currently pointed at by cnt.
    assign boff     = {cnt, 3'b000};
    assign sbox_in  = data[boff +: 8];
    assign sbox_out = SBOX[sbox_in];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            data  <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            data  <= data_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        data_nxt  = data;
        case (state)
            IDLE: begin
                // in_ready is 1 throughout IDLE, so in_valid alone is the accept
                if (bus.in_valid) begin
                    data_nxt  = bus.idat;
                    cnt_nxt   = '0;
                    state_nxt = SUB;
                end
            end
            SUB: begin
                if (bus.abort) begin
                    // leave data as it stands; only the control path is cleared
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                end else begin
                    data_nxt[boff +: 8] = sbox_out;
                    if (cnt == LAST) begin
                        cnt_nxt   = '0;
                        state_nxt = DONE;
                    end else begin
                        cnt_nxt = cnt + CW'(1);
                    end
                end
            end
            DONE: begin
                // abort wins over out_ready: the word is dropped without a handshake
                if (bus.abort) begin
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                end else if (bus.out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                cnt_nxt   = '0;
                state_nxt = IDLE;
            end
        endcase
    end

    // Status flags come straight off the state register, no input-to-output paths.
    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.busy      = (state == SUB) || (state == DONE);
    assign bus.odat      = data;

endmodule

// File: tb/tb_anubis_inv_gamma_serial.sv
// Purpose: self-checking bench for anubis_inv_gamma_serial with a scoreboard queue.
// Latency: expects out_valid 16 edges after accept and an 18-clock accept period.
// Backpressure: exercises out_ready stalls, ignored in_valid, abort in SUB and DONE.
module tb_anubis_inv_gamma_serial;
    localparam int NB = 16;

    localparam logic [7:0] SB [0:255] = '{
        8'hA7, 8'hD3, 8'hE6, 8'h71, 8'hD0, 8'hAC, 8'h4D, 8'h79, 8'h3A, 8'hC9, 8'h91, 8'hFC, 8'h1E, 8'h47, 8'h54, 8'hBD,
        8'h8C, 8'hA5, 8'h7A, 8'hFB, 8'h63, 8'hB8, 8'hDD, 8'hD4, 8'hE5, 8'hB3, 8'hC5, 8'hBE, 8'hA9, 8'h88, 8'h0C, 8'hA2,
        8'h39, 8'hDF, 8'h29, 8'hDA, 8'h2B, 8'hA8, 8'hCB, 8'h4C, 8'h4B, 8'h22, 8'hAA, 8'h24, 8'h41, 8'h70, 8'hA6, 8'hF9,
        8'h5A, 8'hE2, 8'hB0, 8'h36, 8'h7D, 8'hE4, 8'h33, 8'hFF, 8'h60, 8'h20, 8'h08, 8'h8B, 8'h5E, 8'hAB, 8'h7F, 8'h78,
        8'h7C, 8'h2C, 8'h57, 8'hD2, 8'hDC, 8'h6D, 8'h7E, 8'h0D, 8'h53, 8'h94, 8'hC3, 8'h28, 8'h27, 8'h06, 8'h5F, 8'hAD,
        8'h67, 8'h5C, 8'h55, 8'h48, 8'h0E, 8'h52, 8'hEA, 8'h42, 8'h5B, 8'h5D, 8'h30, 8'h58, 8'h51, 8'h59, 8'h3C, 8'h4E,
        8'h38, 8'h8A, 8'h72, 8'h14, 8'hE7, 8'hC6, 8'hDE, 8'h50, 8'h8E, 8'h92, 8'hD1, 8'h77, 8'h93, 8'h45, 8'h9A, 8'hCE,
        8'h2D, 8'h03, 8'h62, 8'hB6, 8'hB9, 8'hBF, 8'h96, 8'h6B, 8'h3F, 8'h07, 8'h12, 8'hAE, 8'h40, 8'h34, 8'h46, 8'h3E,
        8'hDB, 8'hCF, 8'hEC, 8'hCC, 8'hC1, 8'hA1, 8'hC0, 8'hD6, 8'h1D, 8'hF4, 8'h61, 8'h3B, 8'h10, 8'hD8, 8'h68, 8'hA0,
        8'hB1, 8'h0A, 8'h69, 8'h6C, 8'h49, 8'hFA, 8'h76, 8'hC4, 8'h9E, 8'h9B, 8'h6E, 8'h99, 8'hC2, 8'hB7, 8'h98, 8'hBC,
        8'h8F, 8'h85, 8'h1F, 8'hB4, 8'hF8, 8'h11, 8'h2E, 8'h00, 8'h25, 8'h1C, 8'h2A, 8'h3D, 8'h05, 8'h4F, 8'h7B, 8'hB2,
        8'h32, 8'h90, 8'hAF, 8'h19, 8'hA3, 8'hF7, 8'h73, 8'h9D, 8'h15, 8'h74, 8'hEE, 8'hCA, 8'h9F, 8'h0F, 8'h1B, 8'h75,
        8'h86, 8'h84, 8'h9C, 8'h4A, 8'h97, 8'h1A, 8'h65, 8'hF6, 8'hED, 8'h09, 8'hBB, 8'h26, 8'h83, 8'hEB, 8'h6F, 8'h81,
        8'h04, 8'h6A, 8'h43, 8'h01, 8'h17, 8'hE1, 8'h87, 8'hF5, 8'h8D, 8'hE3, 8'h23, 8'h80, 8'h44, 8'h16, 8'h66, 8'h21,
        8'hFE, 8'hD5, 8'h31, 8'hD9, 8'h35, 8'h18, 8'h02, 8'h64, 8'hF2, 8'hF1, 8'h56, 8'hCD, 8'h82, 8'hC8, 8'hBA, 8'hF0,
        8'hEF, 8'hE9, 8'hE8, 8'hFD, 8'h89, 8'hD7, 8'hC7, 8'hB5, 8'hA4, 8'h2F, 8'h95, 8'h13, 8'h0B, 8'hF3, 8'hE0, 8'h37
    };

    typedef struct {
        logic [127:0] idat;
        logic [127:0] exp;
    } vec_t;

    logic clk;
    logic rst_n;
    anubis_inv_gamma_serial_if #(.NBYTES(NB)) bus ();

    anubis_inv_gamma_serial #(.NBYTES(NB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;
    logic [127:0] sb [$];

    // substitute the first n bytes of x, leave the rest raw
    function automatic logic [127:0] gamma_n(input logic [127:0] x, input int n);
        logic [127:0] r;
        r = x;
        for (int i = 0; i < n; i++) r[8*i +: 8] = SB[x[8*i +: 8]];
        return r;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic check_vec(input string name, input logic [127:0] act, input logic [127:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Drive x until accepted, expect `exp` 16 edges later, then handshake it out.
    task automatic run_word(input logic [127:0] x, input logic [127:0] exp,
                            input string name, output logic [127:0] got);
        int t;
        got = '0;
        @(negedge clk);
        bus.idat     = x;
        bus.in_valid = 1'b1;
        t = 0;
        while (!bus.in_ready && t < 50) begin @(negedge clk); t++; end
        if (!bus.in_ready) begin
            check_int({name, " accept timeout"}, 0, 1);
            bus.in_valid = 1'b0;
            return;
        end
        sb.push_back(exp);
        @(negedge clk);
        bus.in_valid = 1'b0;
        t = 0;
        while (!bus.out_valid && t < 40) begin @(negedge clk); t++; end
        check_int({name, " latency"}, t, 16);
        got = bus.odat;
        if (bus.out_valid) begin
            bus.out_ready = 1'b1;
            @(negedge clk);
            bus.out_ready = 1'b0;
        end
        if (sb.size() > 0) check_vec(name, got, sb.pop_front());
    endtask

    // Accept x and stop right after the accept edge (caller is at the following negedge).
    task automatic accept_only(input logic [127:0] x);
        int t;
        @(negedge clk);
        bus.idat     = x;
        bus.in_valid = 1'b1;
        t = 0;
        while (!bus.in_ready && t < 50) begin @(negedge clk); t++; end
        if (!bus.in_ready) check_int("accept timeout", 0, 1);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_out_valid(input string name);
        int t;
        t = 0;
        while (!bus.out_valid && t < 40) begin @(negedge clk); t++; end
        if (!bus.out_valid) check_int({name, " out_valid timeout"}, 0, 1);
    endtask

    initial begin
        vec_t         vt [4];
        logic [127:0] x, y, z, e;
        int           last, accepts, pulses;
        bit           chg;

        vt[0] = '{idat: {16{8'h00}},              exp: {16{8'hA7}}};
        vt[1] = '{idat: {{14{8'hA7}}, 8'h01, 8'h00}, exp: {{14{8'h00}}, 8'hD3, 8'hA7}};
        vt[2] = '{idat: {16{8'hFF}},              exp: {16{8'h37}}};
        vt[3] = '{idat: {8{8'h80, 8'h0B}},        exp: {8{8'hDB, 8'hFC}}};

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.idat      = '0;
        bus.abort     = 1'b0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check_int("reset in_ready", int'(bus.in_ready), 1);
        check_int("reset out_valid", int'(bus.out_valid), 0);
        check_int("reset busy", int'(bus.busy), 0);
        check_vec("reset odat", bus.odat, '0);
        rst_n = 1'b1;

        // reset asserted 5 SUB cycles into a word
        accept_only(rnd128());
        repeat (5) @(negedge clk);
        check_int("busy mid-sub", int'(bus.busy), 1);
        rst_n = 1'b0;
        #1;
        check_int("midreset out_valid", int'(bus.out_valid), 0);
        check_int("midreset in_ready", int'(bus.in_ready), 1);
        check_int("midreset busy", int'(bus.busy), 0);
        check_vec("midreset odat", bus.odat, '0);
        @(negedge clk);
        rst_n = 1'b1;
        sb.delete();
        run_word({16{8'h00}}, {16{8'hA7}}, "post-reset zero", y);

        // table vectors
        for (int i = 0; i < 4; i++) run_word(vt[i].idat, vt[i].exp, $sformatf("vec%0d", i), y);

        // byte order: byte k is substituted by edge k+1
        for (int i = 0; i < 16; i++) x[8*i +: 8] = 8'(i);
        accept_only(x);
        for (int k = 0; k <= 16; k++) begin
            check_vec($sformatf("order edge%0d", k), bus.odat, gamma_n(x, k));
            if (k < 16) @(negedge clk);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;

        // backpressure: DONE held 10 cycles with in_valid pulses ignored
        x = rnd128();
        accept_only(x);
        wait_out_valid("bp");
        for (int k = 0; k < 10; k++) begin
            check_int("bp out_valid", int'(bus.out_valid), 1);
            check_int("bp in_ready", int'(bus.in_ready), 0);
            check_vec("bp odat", bus.odat, gamma_n(x, 16));
            bus.in_valid = k[0];
            bus.idat     = rnd128();
            @(negedge clk);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check_int("bp released in_ready", int'(bus.in_ready), 1);
        check_vec("bp odat kept", bus.odat, gamma_n(x, 16));

        // throughput: in_valid continuous, out_ready tied high
        last = -1;
        accepts = 0;
        chg = 1'b0;
        bus.out_ready = 1'b1;
        bus.idat      = rnd128();
        bus.in_valid  = 1'b1;
        for (int c = 0; c < 90; c++) begin
            @(negedge clk);
            if (chg) begin
                bus.idat = rnd128();
                chg = 1'b0;
                if (accepts == 4) bus.in_valid = 1'b0;
            end
            if (bus.out_valid && sb.size() > 0) check_vec("thru odat", bus.odat, sb.pop_front());
            if (bus.in_ready && bus.in_valid) begin
                if (last >= 0) check_int("accept period", c - last, 18);
                last = c;
                accepts++;
                sb.push_back(gamma_n(bus.idat, 16));
                chg = 1'b1;
            end
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        check_int("thru accepts", accepts, 4);
        check_int("thru drained", sb.size(), 0);
        sb.delete();

        // abort during SUB after 7 bytes
        x = rnd128();
        accept_only(x);
        repeat (7) @(negedge clk);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        check_int("abort sub in_ready", int'(bus.in_ready), 1);
        check_int("abort sub busy", int'(bus.busy), 0);
        check_vec("abort sub odat", bus.odat, gamma_n(x, 7));
        pulses = 0;
        for (int k = 0; k < 20; k++) begin
            if (bus.out_valid) pulses++;
            @(negedge clk);
        end
        check_int("abort sub no out_valid", pulses, 0);
        x = rnd128();
        run_word(x, gamma_n(x, 16), "after abort sub", y);

        // abort together with out_ready in DONE
        x = rnd128();
        accept_only(x);
        wait_out_valid("abort done");
        bus.abort     = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.abort     = 1'b0;
        bus.out_ready = 1'b0;
        check_int("abort done in_ready", int'(bus.in_ready), 1);
        check_int("abort done out_valid", int'(bus.out_valid), 0);
        check_vec("abort done odat", bus.odat, gamma_n(x, 16));
        e = rnd128();
        run_word(e, gamma_n(e, 16), "after abort done", y);

        // involution round trip on random words
        for (int n = 0; n < 1000; n++) begin
            x = rnd128();
            run_word(x, gamma_n(x, 16), "fwd", y);
            run_word(y, x, "inv", z);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached, nvec=%0d", nvec);
        $fatal(1, "watchdog");
    end

endmodule
